// File: rtl/switch_pkg.sv
// switch_pkg: shared constants and types for the switch input port.
//   NUM_PORTS / PORT_IDLE : port numbering (destinations 1..NUM_PORTS, 0 = idle)
//   PORT_W / LEN_W        : width of a port code and of a packet length
//   COUNT_W               : width of queue occupancy counters (covers DEPTH up to 16)
//   desc_t                : queued descriptor {dest, len}
//   state_t               : input port FSM encoding
//   desc_legal()          : filter deciding whether an offered descriptor is stored
package switch_pkg;

  localparam int NUM_PORTS = 8;
  localparam int PORT_W    = 4;
  localparam int LEN_W     = 4;
  localparam int COUNT_W   = 5;

  localparam logic [PORT_W-1:0] PORT_IDLE = '0;
  localparam logic [PORT_W-1:0] PORT_MAX  = PORT_W'(NUM_PORTS);

  typedef struct packed {
    logic [PORT_W-1:0] dest;
    logic [LEN_W-1:0]  len;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // A descriptor is kept only if it names a real output other than the
  // port's own loopback and carries at least one beat.
  function automatic logic desc_legal(input logic [PORT_W-1:0] dest,
                                      input logic [LEN_W-1:0]  len,
                                      input logic [PORT_W-1:0] self_dest);
    return (dest != PORT_IDLE) && (dest <= PORT_MAX) &&
           (len != '0) && (dest != self_dest);
  endfunction

endpackage

// File: rtl/switch_desc_fifo.sv
// switch_desc_fifo: descriptor queue for one switch input port.
//   clock, reset_n : clock and asynchronous active-low reset (empties the queue)
//   push, push_data: write one descriptor (ignored when full)
//   pop            : discard the head descriptor (ignored when empty)
//   head           : current head descriptor (valid when !empty)
//   empty, count   : occupancy status; push and pop together keep count unchanged
module switch_desc_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  desc_t              push_data,
  input  logic               pop,
  output desc_t              head,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  desc_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && (count < COUNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/switch_input_port.sv
// switch_input_port: one input port of an 8-port switch. Queues packet
// descriptors, drops illegal ones, requests the destination output from the
// arbiter and streams the packet beats to the crossbar while granted.
//   clock, reset_n              : clock, asynchronous active-low reset
//   in_valid/in_ready/in_dest/in_len : descriptor input
//   request / grant             : arbiter interface (0 = idle, 1..8 = output)
//   ack                         : one-hot completion pulse, bit dest-1
//   xfer_valid/xfer_ready/xfer_dest/xfer_beat/xfer_last : beat stream
//   drop_count                  : saturating count of dropped descriptors
//   q_count                     : queue occupancy
//   fsm_state                   : current FSM state (observability)
//
// Handshakes: a descriptor is taken on a rising edge where in_valid && in_ready;
// a beat is taken on a rising edge where xfer_valid && xfer_ready. Valid-side
// signals hold their payload until taken; ready never depends on valid.
module switch_input_port
  import switch_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PORT_W-1:0]  in_dest,
  input  logic [LEN_W-1:0]   in_len,
  output logic [PORT_W-1:0]  request,
  input  logic [PORT_W-1:0]  grant,
  output logic [7:0]         ack,
  output logic               xfer_valid,
  input  logic               xfer_ready,
  output logic [PORT_W-1:0]  xfer_dest,
  output logic [LEN_W-1:0]   xfer_beat,
  output logic               xfer_last,
  output logic [7:0]         drop_count,
  output logic [COUNT_W-1:0] q_count,
  output state_t             fsm_state
);

  localparam logic [PORT_W-1:0] SELF_DEST = PORT_W'(PORT_ID + 1);

  state_t             state;
  state_t             state_next;
  logic               ready_en;
  logic               accept;
  logic               legal;
  logic               push;
  logic               drop;
  logic               pop;
  desc_t              head;
  logic               empty;
  logic [LEN_W-1:0]   beat;
  logic               grant_ok;
  logic               at_last;
  logic               beat_fire;
  logic               last_fire;

  // in_ready stays low through reset and rises on the first edge after it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Registered count only: a full queue cannot accept even if it pops this cycle.
  assign in_ready = ready_en && (q_count < COUNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign legal    = desc_legal(in_dest, in_len, SELF_DEST);
  assign push     = accept && legal;
  assign drop     = accept && !legal;

  switch_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({in_dest, in_len}),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (q_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                       drop_count <= '0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end

  // Any grant value other than the head destination counts as no grant.
  assign grant_ok  = (grant == head.dest);
  assign at_last   = (beat == head.len - LEN_W'(1));
  assign beat_fire = (state == ST_XFER) && grant_ok && xfer_ready;
  assign last_fire = beat_fire && at_last;
  assign pop       = last_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      if (beat_fire) beat <= at_last ? '0 : beat + LEN_W'(1);
    end
  end

  // request depends only on registered state and queue head, never on grant.
  always_comb begin
    state_next = state;
    request    = PORT_IDLE;
    case (state)
      ST_IDLE: if (!empty) state_next = ST_REQ;
      ST_REQ: begin
        request = head.dest;
        if (grant_ok) state_next = ST_XFER;
      end
      ST_XFER: begin
        request = head.dest;
        if (last_fire) state_next = ST_GAP;
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign xfer_valid = (state == ST_XFER) && grant_ok;
  assign xfer_dest  = (state == ST_XFER) ? head.dest : PORT_IDLE;
  assign xfer_beat  = beat;
  assign xfer_last  = (state == ST_XFER) && at_last;
  assign ack        = last_fire ? (8'd1 << (head.dest - PORT_W'(1))) : 8'd0;
  assign fsm_state  = state;

endmodule

// File: tb/tb_switch_input_port.sv
module tb_switch_input_port;
  import switch_pkg::*;

  localparam int PORT_ID = 2;
  localparam int DEPTH   = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_dest = '0;
  logic [3:0]  in_len = '0;
  logic [3:0]  request;
  logic [3:0]  grant = '0;
  logic [7:0]  ack;
  logic        xfer_valid;
  logic        xfer_ready = 1'b0;
  logic [3:0]  xfer_dest;
  logic [3:0]  xfer_beat;
  logic        xfer_last;
  logic [7:0]  drop_count;
  logic [4:0]  q_count;
  state_t      fsm_state;

  int checks = 0;
  int passes = 0;
  int ack_count = 0;

  // Expected beats {dest[8:5], beat[4:1], last[0]} in delivery order.
  logic [8:0] exp_q[$];

  typedef struct {
    logic [3:0] dest;
    logic [3:0] len;
    logic [7:0] exp_drops;
    logic [4:0] exp_q;
  } vec_t;
  vec_t vecs[6];

  switch_input_port #(.PORT_ID(PORT_ID), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_len(in_len),
    .request(request), .grant(grant), .ack(ack),
    .xfer_valid(xfer_valid), .xfer_ready(xfer_ready), .xfer_dest(xfer_dest),
    .xfer_beat(xfer_beat), .xfer_last(xfer_last),
    .drop_count(drop_count), .q_count(q_count), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] onehot(input logic [3:0] d);
    logic [7:0] one;
    one = 8'd1;
    return one << (d - 4'd1);
  endfunction

  function automatic logic is_legal(input logic [3:0] d, input logic [3:0] l);
    return (d >= 4'd1) && (d <= 4'd8) && (d != 4'(PORT_ID + 1)) && (l != 4'd0);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [7:0] exp_ack;
    logic [8:0] e;
    exp_ack = 8'd0;
    if (xfer_valid && xfer_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {23'd0, xfer_dest, xfer_beat, xfer_last}, 32'h1FF);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {23'd0, xfer_dest, xfer_beat, xfer_last}, {23'd0, e});
        if (e[0]) exp_ack = onehot(e[8:5]);
      end
    end
    chk("ack", {24'd0, ack}, {24'd0, exp_ack});
    if (ack != 8'd0) ack_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_dest = '0; in_len = '0;
    grant = '0; xfer_ready = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_request", {28'd0, request}, 32'd0);
    chk("rst_q_count", {27'd0, q_count}, 32'd0);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    @(posedge clock); #1;
    reset_n = 1'b1;
    tick();
    @(negedge clock);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic offer(input logic [3:0] d, input logic [3:0] l);
    int n;
    n = 0;
    in_valid = 1'b1; in_dest = d; in_len = l;
    @(negedge clock);
    while (!in_ready && n < 100) begin @(negedge clock); n++; end
    if (!in_ready) chk("offer_timeout", 32'd0, 32'd1);
    if (is_legal(d, l))
      for (int b = 0; b < int'(l); b++) exp_q.push_back({d, 4'(b), (b == int'(l) - 1)});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic serve(input logic [3:0] d, input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while (request !== d && n < 60) begin @(negedge clock); n++; end
    chk({tag, "_req"}, {28'd0, request}, {28'd0, d});
    tick();
    grant = d; xfer_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (ack === 8'd0 && n < 60) begin @(negedge clock); n++; end
    chk({tag, "_ack"}, {24'd0, ack}, {24'd0, onehot(d)});
    tick();
    grant = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int a0;
    vecs[0] = '{dest: 4'd3,  len: 4'd2,  exp_drops: 8'd1, exp_q: 5'd0};
    vecs[1] = '{dest: 4'd0,  len: 4'd2,  exp_drops: 8'd2, exp_q: 5'd0};
    vecs[2] = '{dest: 4'd5,  len: 4'd0,  exp_drops: 8'd3, exp_q: 5'd0};
    vecs[3] = '{dest: 4'd9,  len: 4'd1,  exp_drops: 8'd4, exp_q: 5'd0};
    vecs[4] = '{dest: 4'd15, len: 4'd15, exp_drops: 8'd5, exp_q: 5'd0};
    vecs[5] = '{dest: 4'd8,  len: 4'd1,  exp_drops: 8'd5, exp_q: 5'd1};

    // Basic packet: dest 5, 3 beats, grant two cycles after request.
    do_reset();
    a0 = ack_count;
    offer(4'd5, 4'd3);
    n = 0;
    @(negedge clock);
    while (request !== 4'd5 && n < 20) begin @(negedge clock); n++; end
    chk("basic_req", {28'd0, request}, 32'd5);
    tick();
    @(negedge clock);
    chk("basic_wait_req", {28'd0, request}, 32'd5);
    chk("basic_wait_valid", {31'd0, xfer_valid}, 32'd0);
    tick();
    grant = 4'd5; xfer_ready = 1'b1;
    @(negedge clock);
    chk("basic_req_state", {30'd0, fsm_state}, {30'd0, ST_REQ});
    chk("basic_no_valid", {31'd0, xfer_valid}, 32'd0);
    for (int b = 0; b < 3; b++) begin
      tick();
      @(negedge clock);
      chk("basic_valid", {31'd0, xfer_valid}, 32'd1);
      chk("basic_beat", {28'd0, xfer_beat}, b);
      chk("basic_last", {31'd0, xfer_last}, (b == 2) ? 32'd1 : 32'd0);
    end
    chk("basic_ack", {24'd0, ack}, 32'h10);
    tick();
    @(negedge clock);
    chk("basic_gap_state", {30'd0, fsm_state}, {30'd0, ST_GAP});
    chk("basic_gap_req", {28'd0, request}, 32'd0);
    tick();
    @(negedge clock);
    chk("basic_idle_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    chk("basic_idle_req", {28'd0, request}, 32'd0);
    chk("basic_q_empty", {27'd0, q_count}, 32'd0);
    chk("basic_ack_once", ack_count - a0, 32'd1);
    tick();
    grant = '0;

    // Drop filter table.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      offer(vecs[i].dest, vecs[i].len);
      @(negedge clock);
      chk($sformatf("drop_cnt_%0d", i), {24'd0, drop_count}, {24'd0, vecs[i].exp_drops});
      chk($sformatf("drop_q_%0d", i), {27'd0, q_count}, {27'd0, vecs[i].exp_q});
      if (!is_legal(vecs[i].dest, vecs[i].len))
        chk($sformatf("drop_req_%0d", i), {28'd0, request}, 32'd0);
      tick();
    end
    serve(4'd8, "drop_serve");

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) offer(4'd0, 4'd1);
    @(negedge clock);
    chk("drop_saturate", {24'd0, drop_count}, 32'd255);
    tick();

    // Full queue backpressure; a fifth offer stalls until the first pop.
    do_reset();
    for (int i = 0; i < 4; i++) offer(4'd6, 4'd2);
    @(negedge clock);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    chk("full_count", {27'd0, q_count}, 32'd4);
    tick();
    in_valid = 1'b1; in_dest = 4'd7; in_len = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("full_stall", {31'd0, in_ready}, 32'd0);
      tick();
    end
    grant = 4'd6; xfer_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 40) begin @(negedge clock); n++; end
    chk("full_reopen", {31'd0, in_ready}, 32'd1);
    chk("full_after_pop", {27'd0, q_count}, 32'd3);
    for (int b = 0; b < 1; b++) exp_q.push_back({4'd7, 4'd0, 1'b1});
    tick();
    in_valid = 1'b0; grant = '0;
    @(negedge clock);
    chk("full_refill", {27'd0, q_count}, 32'd4);
    tick();
    for (int i = 0; i < 3; i++) serve(4'd6, "full_drain");
    serve(4'd7, "full_last");

    // Grant withdrawn / changed mid-packet.
    do_reset();
    a0 = ack_count;
    offer(4'd7, 4'd4);
    tick();
    grant = 4'd7; xfer_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (!(xfer_valid && xfer_beat == 4'd1) && n < 40) begin @(negedge clock); n++; end
    chk("gdrop_reach", {28'd0, xfer_beat}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      grant = (i == 2) ? 4'd3 : 4'd0;
      @(negedge clock);
      chk("gdrop_valid", {31'd0, xfer_valid}, 32'd0);
      chk("gdrop_hold", {28'd0, xfer_beat}, 32'd2);
      chk("gdrop_req", {28'd0, request}, 32'd7);
    end
    chk("gdrop_no_ack", ack_count - a0, 32'd0);
    serve(4'd7, "gdrop_resume");

    // xfer_ready stalls on the last beat; accept coincides with a new enqueue.
    do_reset();
    offer(4'd4, 4'd2);
    tick();
    grant = 4'd4; xfer_ready = 1'b0;
    n = 0;
    @(negedge clock);
    while (!xfer_valid && n < 40) begin tick(); @(negedge clock); n++; end
    chk("stall_b0", {28'd0, xfer_beat}, 32'd0);
    tick();
    xfer_ready = 1'b1;
    tick();
    xfer_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_last", {31'd0, xfer_last}, 32'd1);
      chk("stall_beat", {28'd0, xfer_beat}, 32'd1);
      tick();
    end
    xfer_ready = 1'b1;
    in_valid = 1'b1; in_dest = 4'd8; in_len = 4'd1;
    exp_q.push_back({4'd8, 4'd0, 1'b1});
    @(negedge clock);
    chk("stall_ack", {24'd0, ack}, 32'h08);
    chk("stall_ready", {31'd0, in_ready}, 32'd1);
    chk("stall_q_before", {27'd0, q_count}, 32'd1);
    tick();
    in_valid = 1'b0; grant = '0;
    @(negedge clock);
    chk("stall_q_same", {27'd0, q_count}, 32'd1);
    tick();
    serve(4'd8, "stall_next");

    // Reset during beat 1 of a 4-beat packet.
    do_reset();
    offer(4'd5, 4'd4);
    tick();
    grant = 4'd5; xfer_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (!(xfer_valid && xfer_beat == 4'd1) && n < 40) begin @(negedge clock); n++; end
    a0 = ack_count;
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_req", {28'd0, request}, 32'd0);
    chk("mid_rst_ack", {24'd0, ack}, 32'd0);
    chk("mid_rst_valid", {31'd0, xfer_valid}, 32'd0);
    chk("mid_rst_beat", {28'd0, xfer_beat}, 32'd0);
    chk("mid_rst_last", {31'd0, xfer_last}, 32'd0);
    chk("mid_rst_q", {27'd0, q_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    @(negedge clock);
    chk("post_rst_req", {28'd0, request}, 32'd0);
    chk("post_rst_q", {27'd0, q_count}, 32'd0);
    chk("post_rst_no_ack", ack_count - a0, 32'd0);
    grant = '0;
    tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/switch_input_port.md
SWITCH_INPUT_PORT -- requirements
Module: switch_input_port

Interface
REQ-001 Parameter PORT_ID, default 0, input port index 0-7 served by this instance.
REQ-002 Parameter DEPTH, default 4, descriptor queue entries (power of 2, 2-16).
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  descriptor offered.
REQ-006 in_ready  output  1  queue can accept descriptor.
REQ-007 in_dest  input  4  destination output, 1-8 legal, 0/9-15 illegal.
REQ-008 in_len  input  4  packet length in beats, 1-15 legal, 0 illegal.
REQ-009 request  output  4  to arbiter request_<PORT_ID>: 0=idle, 1-8=output.
REQ-010 grant  input  4  from arbiter grant_<PORT_ID>: 0=none, 1-8=output.
REQ-011 ack  output  8  one-hot, ack[dest-1]; OR-combined across ports at top level.
REQ-012 xfer_valid  output  1  data beat valid to crossbar.
REQ-013 xfer_ready  input  1  crossbar accepts beat.
REQ-014 xfer_dest  output  4  destination of current beat.
REQ-015 xfer_beat  output  4  beat index, 0-based.
REQ-016 xfer_last  output  1  final beat of packet.
REQ-017 drop_count  output  8  saturating count of dropped descriptors.
REQ-018 q_count  output  5  current queue occupancy.

Function
REQ-019 Enqueue on in_valid && in_ready; in_ready = (q_count < DEPTH).
REQ-020 Descriptor with illegal dest, in_len==0, or dest==PORT_ID+1 (self) SHALL be consumed (in_ready honoured), not stored, and drop_count incremented, saturating at 255.
REQ-021 FSM states IDLE, REQ, XFER, GAP.
REQ-022 IDLE: request=0; go REQ when queue non-empty.
REQ-023 REQ: request=head dest; go XFER when grant==head dest; other grant values ignored.
REQ-024 XFER: request=head dest held; xfer_valid=1 only while grant==head dest; beat advances on xfer_valid && xfer_ready.
REQ-025 Beat counter 4-bit, starts 0, xfer_last=1 when xfer_beat==len-1.
REQ-026 On last-beat handshake: ack[dest-1] pulses exactly one cycle (same cycle), head popped, go GAP.
REQ-027 GAP: request=0 for exactly one cycle, stale grant ignored, then IDLE.
REQ-028 If grant deasserts or changes in XFER, xfer_valid=0 and beat index holds until grant returns.
REQ-029 Simultaneous enqueue and pop SHALL leave q_count unchanged; enqueue into full queue with same-cycle pop NOT allowed (in_ready uses registered count).
REQ-030 ack is zero in all cycles except REQ-026 pulse.

Reset
REQ-031 reset_n low: state IDLE, queue empty, q_count=0, request=0, ack=0, xfer_valid=0, xfer_beat=0, xfer_last=0, drop_count=0, in_ready=0 while asserted, 1 first cycle after release.
REQ-032 Reset mid-transfer SHALL discard all queued and in-flight packets with no ack emitted.

Structure
REQ-033 Shared package switch_pkg holds NUM_PORTS=8, PORT_IDLE=0, port encoding width 4, length width 4, FSM state encoding.
REQ-034 Descriptor queue implemented as sub-module switch_desc_fifo (8-bit entries {dest,len}, DEPTH parameter, push/pop/count).
REQ-035 Beat counter, FSM, drop filter in top module; no combinational path from grant to request.

Verification
REQ-036 PORT_ID=2; enqueue dest=5,len=3; grant=5 two cycles after request -> 3 beats idx 0,1,2, xfer_last on beat 2, ack=8'h10 one cycle, request=0 one cycle.
REQ-037 PORT_ID=2; enqueue dest=3 (self), dest=0, len=0 -> none stored, drop_count=3, request stays 0.
REQ-038 Fill 4 descriptors -> in_ready=0, q_count=4; 5th offer stalls; after first pop in_ready=1.
REQ-039 XFER with grant dropped to 0 for 2 cycles mid-packet -> xfer_valid=0 those cycles, beat index held, no ack.
REQ-040 xfer_ready low 3 cycles on last beat -> xfer_last held, ack only on accepting cycle.
REQ-041 reset_n low during beat 1 of len=4 packet -> all outputs to reset values, q_count=0, no ack.
